// File: rtl/glb_reader_pkg.sv
// Shared types and constants for the GLB reader.
package glb_reader_pkg;

  localparam int unsigned GLB_ADDR_W   = 32;
  localparam int unsigned GLB_DATA_W   = 32;
  localparam int unsigned GLB_WORD_INC = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } glb_rd_state_t;

endpackage

// File: rtl/glb_rd_fifo.sv
// Two-entry show-ahead FIFO; head is valid whenever the FIFO is not empty.
module glb_rd_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Zero when empty so the stream data reads 0 outside a valid word.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/glb_reader.sv
// Reads len consecutive words from the GLB and streams them out with
// valid/ready flow control, never holding more than two words in flight.
module glb_reader
  import glb_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = GLB_ADDR_W,
  parameter int unsigned DATA_W = GLB_DATA_W,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              glb_re,
  output logic [ADDR_W-1:0] glb_r_addr,
  input  logic [DATA_W-1:0] glb_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  glb_rd_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_idx_q;
  logic [LEN_W-1:0]  pop_cnt_q;
  logic              inflight_q;

  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Words already buffered or on their way, less the one leaving this cycle.
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (occupancy < 3'd2);
  assign fifo_push = inflight_q & ~fifo_full;

  assign glb_re     = issue;
  assign glb_r_addr = issue ? addr_q : '0;
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_head;
  assign out_last   = out_valid && (pop_cnt_q == len_q - LEN_W'(1));
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == FINISH);

  glb_rd_fifo #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (glb_dout),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (issue && (rd_idx_q == len_q - LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if ((state_q == IDLE) && start) begin
        addr_q    <= base_addr;
        len_q     <= len;
        rd_idx_q  <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(GLB_WORD_INC);
          rd_idx_q <= rd_idx_q + LEN_W'(1);
        end
        if (pop) begin
          pop_cnt_q <= pop_cnt_q + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_glb_reader.sv
// Scoreboard bench for glb_reader: expected addresses and words are queued
// when a transfer is started and checked as the DUT produces them.
module tb_glb_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        glb_re;
  logic [31:0] glb_r_addr;
  logic [31:0] glb_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          outstanding;
  logic        prev_stall;
  logic [31:0] prev_data;
  int          errors;
  int          checks;

  glb_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .glb_re     (glb_re),
    .glb_r_addr (glb_r_addr),
    .glb_dout   (glb_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // GLB memory model: one-cycle read latency.
  always @(posedge clk) glb_dout <= glb_re ? mem_word(glb_r_addr) : 32'h0;

  task automatic push_expected(input logic [31:0] b, input int n);
    exp_t e;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      exp_addr_q.push_back(a);
      e.data = mem_word(a);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
  endtask

  // Called just before a rising edge; leaves time at the negedge of cycle 1.
  task automatic kick(input logic [31:0] b, input logic [15:0] n);
    start      = 1'b1;
    base_addr  = b;
    len        = n;
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Per-cycle scoreboard: read addresses, pending limit, stream words.
  task automatic sb_cycle();
    logic  pop;
    exp_t  e;
    logic [31:0] a;
    pop = out_valid && out_ready;
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        errors++;
        $display("FAIL hold_stable valid=%b data=%h required valid=1 data=%h",
                 out_valid, out_data, prev_data);
      end
    end
    if (glb_re === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read addr=%h required no read", glb_r_addr);
      end else begin
        a = exp_addr_q.pop_front();
        if (glb_r_addr !== a) begin
          errors++;
          $display("FAIL read_addr got=%h required=%h", glb_r_addr, a);
        end
      end
      checks++;
      if (outstanding - (pop ? 1 : 0) >= 2) begin
        errors++;
        $display("FAIL read_with_two_pending pending=%0d required <2", outstanding);
      end
      outstanding++;
    end else begin
      checks++;
      if (glb_r_addr !== 32'h0) begin
        errors++;
        $display("FAIL idle_addr got=%h required=00000000", glb_r_addr);
      end
    end
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_word data=%h required no word", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL stream_word data=%h last=%b required data=%h last=%b",
                   out_data, out_last, e.data, e.last);
        end
      end
      outstanding--;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int done_cyc);
    done_cyc = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) @(negedge clk);
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      sb_cycle();
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout got=none required done within %0d cycles", budget);
    end
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover words=%0d addrs=%0d required 0/0", exp_q.size(),
               exp_addr_q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, glb_re, glb_r_addr, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b re=%b addr=%h valid=%b data=%h last=%b required all 0",
               busy, done, glb_re, glb_r_addr, out_valid, out_data, out_last);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic exp_re, exp_valid, exp_last, exp_done, exp_busy;
    repeat (2) @(negedge clk);
    clear_sb();
    push_expected(32'h100, 4);
    kick(32'h100, 16'd4);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      out_ready = 1'b1;
      #1;
      sb_cycle();
      exp_re    = (cyc >= 1 && cyc <= 4);
      exp_valid = (cyc >= 3 && cyc <= 6);
      exp_last  = (cyc == 6);
      exp_done  = (cyc == 7);
      exp_busy  = (cyc >= 1 && cyc <= 6);
      checks++;
      if ({glb_re, out_valid, out_last, done, busy} !==
          {exp_re, exp_valid, exp_last, exp_done, exp_busy}) begin
        errors++;
        $display("FAIL basic_timing cycle=%0d re/valid/last/done/busy=%b%b%b%b%b required %b%b%b%b%b",
                 cyc, glb_re, out_valid, out_last, done, busy,
                 exp_re, exp_valid, exp_last, exp_done, exp_busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_leftover words=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    repeat (2) @(negedge clk);
    clear_sb();
    kick(32'h200, 16'd0);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      sb_cycle();
      checks++;
      if (done !== (cyc == 1) || glb_re !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL len0 cycle=%0d done=%b re=%b valid=%b required done=%b re=0 valid=0",
                 cyc, done, glb_re, out_valid, (cyc == 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int dc;
    repeat (2) @(negedge clk);
    clear_sb();
    push_expected(32'h300, 5);
    kick(32'h300, 16'd5);
    wait_done(60, 1'b1, dc);
  endtask

  task automatic test_ignore_start();
    repeat (2) @(negedge clk);
    clear_sb();
    push_expected(32'h400, 6);
    kick(32'h400, 16'd6);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start     = (cyc == 3 || cyc == 9);
      base_addr = 32'h900;
      len       = 16'd3;
      out_ready = 1'b1;
      #1;
      sb_cycle();
      if (cyc == 9) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL ignore_done_cycle done=%b required 1", done);
        end
      end
      if (cyc >= 10) begin
        checks++;
        if (glb_re !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL start_in_done_honoured cycle=%0d re=%b busy=%b required 0/0",
                   cyc, glb_re, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_leftover words=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    repeat (2) @(negedge clk);
    clear_sb();
    push_expected(32'h500, 8);
    kick(32'h500, 16'd8);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      sb_cycle();
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, glb_re, glb_r_addr, out_valid, out_data, out_last} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs busy=%b done=%b re=%b addr=%h valid=%b data=%h last=%b required all 0",
               busy, done, glb_re, glb_r_addr, out_valid, out_data, out_last);
    end
    clear_sb();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold done=%b valid=%b required 0/0", done, out_valid);
    end
    rst = 1'b1;
    push_expected(32'h600, 2);
    kick(32'h600, 16'd2);
    wait_done(20, 1'b0, dc);
    checks++;
    if (dc != 5) begin
      errors++;
      $display("FAIL after_reset_done_cycle got=%0d required 5", dc);
    end
  endtask

  task automatic test_wrap();
    int dc;
    repeat (2) @(negedge clk);
    clear_sb();
    push_expected(32'hFFFF_FFFC, 2);
    kick(32'hFFFF_FFFC, 16'd2);
    wait_done(20, 1'b0, dc);
    checks++;
    if (dc != 5) begin
      errors++;
      $display("FAIL wrap_done_cycle got=%0d required 5", dc);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = 32'h0;
    len       = 16'h0;
    out_ready = 1'b1;
    clear_sb();
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_ignore_start();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
